// File: rtl/seq_control_unit.sv
// Multi-cycle instruction sequencer: variable-length fetch over a ready-handshaked
// program memory, one-cycle decode, configurable execute length, interrupts at boundaries.
module seq_control_unit #(
  parameter int MAX_BYTES   = 3,
  parameter int WAIT_STATES = 1,
  parameter int EXEC_CYCLES = 1,
  parameter int IDX_W       = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic             mem_ready,
  input  logic [2:0]       ins_len,
  input  logic             is_jump,
  input  logic             irq_pending,
  input  logic             irq_en,
  output logic             mem_req,
  output logic             ir_load,
  output logic             byte_load,
  output logic [IDX_W-1:0] byte_idx,
  output logic             pc_inc,
  output logic             decode_en,
  output logic             exec_en,
  output logic             jmp_load,
  output logic             int_ack,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_INT
  } state_t;

  localparam logic [2:0] MAX_LEN = 3'(MAX_BYTES);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);
  localparam logic [2:0] EX_INIT = 3'(EXEC_CYCLES - 1);

  state_t           state;
  logic [2:0]       len;
  logic [IDX_W-1:0] idx;
  logic [3:0]       wait_cnt;
  logic [2:0]       exec_cnt;

  logic       act, capture, last_byte;
  logic [2:0] clamp_len, cur_len;

  always_comb begin
    act       = !reset && !hold;
    capture   = act && (state == S_WAIT) && (wait_cnt == 4'd0) && mem_ready;
    clamp_len = (ins_len == 3'd0) ? 3'd1 : ((ins_len > MAX_LEN) ? MAX_LEN : ins_len);
    // byte 0 decides the length in the same cycle it is captured
    cur_len   = (idx == '0) ? clamp_len : len;
    last_byte = (int'(idx) + 1) >= int'(cur_len);
  end

  assign mem_req   = act && (state == S_FETCH);
  assign byte_load = capture;
  assign pc_inc    = capture;
  assign ir_load   = capture && (idx == '0);
  assign byte_idx  = capture ? idx : '0;
  assign decode_en = act && (state == S_DECODE);
  assign exec_en   = act && (state == S_EXEC);
  assign int_ack   = act && (state == S_INT);
  // exec_cnt only equals its load value on the first EXECUTE cycle
  assign jmp_load  = act && ((state == S_INT) ||
                             ((state == S_EXEC) && (exec_cnt == EX_INIT) && is_jump));
  assign busy      = !reset && (state != S_START);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_START;
      len      <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      exec_cnt <= '0;
    end else if (!hold) begin
      case (state)
        S_START: begin
          idx   <= '0;
          state <= (irq_pending && irq_en) ? S_INT : S_FETCH;
        end
        S_FETCH: begin
          wait_cnt <= WS_INIT;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (capture) begin
            if (idx == '0) len <= clamp_len;
            if (last_byte) begin
              state <= S_DECODE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DECODE: begin
          exec_cnt <= EX_INIT;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_cnt == 3'd0) state <= S_START;
          else                  exec_cnt <= exec_cnt - 3'd1;
        end
        S_INT: begin
          idx   <= '0;
          state <= S_FETCH;
        end
        default: state <= S_START;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Bench for seq_control_unit: each instruction is walked as a scripted sequence of
// expected cycles, with random noise on inputs that must be ignored, random holds and stalls.
module tb_seq_control_unit;

  localparam int MB = 3;
  localparam int WS = 1;
  localparam int EC = 3;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset, hold, mem_ready, is_jump, irq_pending, irq_en;
  logic [2:0]    ins_len;
  logic          mem_req, ir_load, byte_load, pc_inc, decode_en, exec_en, jmp_load, int_ack, busy;
  logic [IW-1:0] byte_idx;
  logic [10:0]   obs;

  int n_vec = 0, n_err = 0, pc_cnt = 0, hold_rate = 0;

  seq_control_unit #(.MAX_BYTES(MB), .WAIT_STATES(WS), .EXEC_CYCLES(EC), .IDX_W(IW)) dut (
    .clock(clock), .reset(reset), .hold(hold), .mem_ready(mem_ready), .ins_len(ins_len),
    .is_jump(is_jump), .irq_pending(irq_pending), .irq_en(irq_en), .mem_req(mem_req),
    .ir_load(ir_load), .byte_load(byte_load), .byte_idx(byte_idx), .pc_inc(pc_inc),
    .decode_en(decode_en), .exec_en(exec_en), .jmp_load(jmp_load), .int_ack(int_ack), .busy(busy)
  );

  always #5 clock = ~clock;

  assign obs = {busy, mem_req, ir_load, byte_load, byte_idx, pc_inc, decode_en, exec_en, jmp_load, int_ack};

  function automatic logic [10:0] ex(bit bz, bit mr, bit il, bit bl, logic [1:0] bi,
                                     bit pi, bit de, bit ee, bit jl, bit ia);
    return {bz, mr, il, bl, bi, pi, de, ee, jl, ia};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic noise();
    mem_ready   = 1'($urandom);
    ins_len     = 3'($urandom);
    is_jump     = 1'($urandom);
    irq_pending = 1'($urandom);
    irq_en      = 1'($urandom);
  endtask

  // one functional cycle, optionally preceded by frozen hold cycles
  task automatic step(input string tag, input logic [10:0] e);
    if (!reset && hold_rate != 0 && $urandom_range(hold_rate - 1) == 0) begin
      int n;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        hold = 1'b1;
        @(negedge clock);
        if (pc_inc) pc_cnt++;
        chk({tag, "/hold"}, 32'(obs), 32'({e[10], 10'b0}));
        @(posedge clock); #1;
      end
    end
    hold = reset ? 1'($urandom) : 1'b0;
    @(negedge clock);
    if (pc_inc) pc_cnt++;
    chk(tag, 32'(obs), 32'(e));
    @(posedge clock); #1;
    hold = 1'b0;
  endtask

  // abort: 0 none, 1 reset in first WAIT cycle, 2 reset in second EXECUTE cycle
  task automatic instr(input int raw, input bit jmp, input bit irq, input bit en,
                       input int stalls, input int abort);
    int len, ns, pc0;
    len = (raw == 0) ? 1 : ((raw > MB) ? MB : raw);
    noise(); irq_pending = irq; irq_en = en;
    step("start", ex(0,0,0,0,0,0,0,0,0,0));
    if (irq && en) begin
      noise();
      step("int", ex(1,0,0,0,0,0,0,0,1,1));
    end
    pc0 = pc_cnt;
    for (int b = 0; b < len; b++) begin
      noise();
      step("fetch", ex(1,1,0,0,0,0,0,0,0,0));
      for (int w = 0; w < WS; w++) begin
        noise();
        if (abort == 1 && b == 0 && w == 0) begin
          reset = 1'b1;
          step("rst_wait", '0);
          reset = 1'b0;
          return;
        end
        step("wait", ex(1,0,0,0,0,0,0,0,0,0));
      end
      ns = (stalls < 0) ? $urandom_range(0, 3) : stalls;
      for (int s = 0; s < ns; s++) begin
        noise(); mem_ready = 1'b0;
        step("stall", ex(1,0,0,0,0,0,0,0,0,0));
      end
      noise(); mem_ready = 1'b1;
      if (b == 0) ins_len = 3'(raw);
      step("capture", ex(1,0,b == 0,1,2'(b),1,0,0,0,0));
    end
    chk("pc_inc_count", 32'(pc_cnt - pc0), 32'(len));
    noise();
    step("decode", ex(1,0,0,0,0,0,1,0,0,0));
    for (int e = 0; e < EC; e++) begin
      noise();
      if (e == 0) is_jump = jmp;
      if (abort == 2 && e == 1) begin
        reset = 1'b1;
        step("rst_exec", '0);
        reset = 1'b0;
        return;
      end
      step("exec", ex(1,0,0,0,0,0,0,1,(e == 0) && jmp,0));
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; noise();
    step("reset0", '0);
    step("reset1", '0);
    reset = 1'b0;

    instr(1, 0, 0, 0, 0, 0);
    instr(3, 1, 0, 0, 0, 0);
    instr(0, 0, 0, 0, 0, 0);
    instr(7, 1, 0, 0, 0, 0);
    instr(2, 0, 0, 0, 4, 0);
    instr(1, 1, 1, 1, 0, 0);
    instr(2, 0, 1, 0, 0, 0);
    instr(3, 0, 0, 0, 0, 2);
    instr(2, 1, 0, 0, 0, 1);
    hold_rate = 3;
    instr(3, 1, 0, 0, 1, 0);
    instr(1, 0, 1, 1, 0, 0);

    hold_rate = 5;
    for (int k = 0; k < 300; k++) begin
      instr($urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom), -1,
            ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0);
    end
    hold_rate = 0;
    instr(1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
